apb_fifo_slave: RTL

APB_FIFO_SLAVE -- requirements
Module: apb_fifo_slave

---
 rtl/apb_fifo_pkg.sv | 46 ++++
 rtl/apb_fifo_mem.sv | 75 +++++++
 rtl/apb_fifo_slave.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/apb_fifo_pkg.sv
// Shared register map, status/control bit positions and slave FSM encoding.
// Latency: n/a (constants and a pure packing function).
// Backpressure: n/a.
package apb_fifo_pkg;

    // Register offsets as decoded from PADDR[3:2]
    localparam logic [1:0] REG_FSR  = 2'd0;
    localparam logic [1:0] REG_FWD  = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_RSV  = 2'd3;

    // FSR bit positions
    localparam int FSR_EMPTY   = 0;
    localparam int FSR_FULL    = 1;
    localparam int FSR_OVF     = 2;
    localparam int FSR_EN      = 3;
    localparam int FSR_CNT_LSB = 8;

    // CTRL bit positions
    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    // APB slave FSM: every access takes one fixed wait state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_state_e;

    // Assemble the FSR word; unused bits read as zero
    function automatic logic [31:0] fsr_pack(input logic       empty,
                                             input logic       full,
                                             input logic       ovf,
                                             input logic       en,
                                             input logic [7:0] cnt);
        logic [31:0] w;
        w                              = '0;
        w[FSR_EMPTY]                   = empty;
        w[FSR_FULL]                    = full;
        w[FSR_OVF]                     = ovf;
        w[FSR_EN]                      = en;
        w[FSR_CNT_LSB +: 8]            = cnt;
        return w;
    endfunction

endpackage

// File: rtl/apb_fifo_mem.sv
// Circular FIFO storage with pointers and occupancy count; clr empties it.
// Latency: write visible at head one cycle after push; dout is combinational from head.
// Backpressure: push while full is refused unless a pop happens the same cycle; clr beats both.
module apb_fifo_mem
    import apb_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clr_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and count update; clr discards any coincident push or pop
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
            else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer/count registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents are don't-care after reset
    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB slave that pushes words into a FIFO drained by a valid/ready stream, with status and control registers.
// Latency: every APB access takes one wait state; write effects commit at the end of the response cycle.
// Backpressure: stream holds head while out_ready is low; a push into a full FIFO is dropped and flagged as overflow.
module apb_fifo_slave
    import apb_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [31:0]   PADDR,
    input  logic [31:0]   PWDATA,
    output logic [31:0]   PRDATA,
    output logic          PREADY,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    apb_state_e  state_q, state_d;
    logic [1:0]  addr_q,  addr_d;
    logic        wr_q,    wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        en_q,    en_d;
    logic        ovf_q,   ovf_d;

    logic [31:0]   rd_mux;
    logic          commit;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_clr;
    logic          ctrl_wr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_bits;

    // Only PADDR[3:2], CTRL bits and the low DW data bits carry meaning
    assign unused_bits = ^{PADDR, PWDATA, wdata_q};

    // Side effects fire once, on the edge that closes the response cycle
    assign commit    = (state_q == ST_RESP) && wr_q;
    assign fifo_push = commit && (addr_q == REG_FWD);
    assign ctrl_wr   = commit && (addr_q == REG_CTRL);
    assign fifo_clr  = ctrl_wr && wdata_q[CTRL_CLR];

    assign out_valid = !fifo_empty && en_q;
    assign fifo_pop  = out_valid && out_ready;

    assign PREADY = (state_q == ST_RESP);
    assign PRDATA = ((state_q == ST_RESP) && !wr_q) ? rdata_q : 32'h0;

    // Read data source for the register selected during the wait state
    always_comb begin
        rd_mux = 32'h0;
        case (PADDR[3:2])
            REG_FSR:  rd_mux = fsr_pack(fifo_empty, fifo_full, ovf_q, en_q, 8'(fifo_count));
            REG_CTRL: rd_mux[CTRL_EN] = en_q;
            default:  rd_mux = 32'h0;
        endcase
    end

    // Slave FSM and capture of the transfer in the wait state
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A master dropping PSEL here aborts the transfer silently
                if (PSEL) begin
                    state_d = ST_RESP;
                    addr_d  = PADDR[3:2];
                    wr_d    = PWRITE;
                    wdata_d = PWDATA;
                    rdata_d = PWRITE ? 32'h0 : rd_mux;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and sticky overflow; clr clears overflow and wins over a dropped push
    always_comb begin
        en_d  = en_q;
        ovf_d = ovf_q;
        if (ctrl_wr) en_d = wdata_q[CTRL_EN];
        if (fifo_clr) begin
            ovf_d = 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_d = 1'b1;
        end
    end

    // Register stage with synchronous reset; reset also aborts any in-flight transfer
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            addr_q  <= 2'b00;
            wr_q    <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            en_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            en_q    <= en_d;
            ovf_q   <= ovf_d;
        end
    end

    apb_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .clr_i   (fifo_clr),
        .din_i   (wdata_q[DW-1:0]),
        .dout_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
